pipe_buffer: RTL and testbench
==============================

# pipe_buffer

Parametrised elastic buffer placed between two pipeline stages (fetch→decode, decode→execute, …), carrying one packed stage payload such as `fetch_data_t` or `decode_data_t` per entry. It generalises the plain stage register in three ways:
- configurable payload width and depth;
- valid/ready back-pressure;
- a synchronous flush for branch/exception recovery.

An optional fall-through mode gives zero-latency pass-through when the buffer is empty.

## Interface
Parameters:
- `WIDTH`, 32: payload bits per entry; set from `$bits(<stage struct>)` at instantiation.
- `DEPTH`, 2: number of entries, 1..8; need not be a power of two.
- `PASS`, 0: 0 = registered, minimum latency 1 cycle; 1 = fall-through when empty, latency 0.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `flush`  in  1  discard all stored entries and the entry offered this cycle.
- `in_valid`  in  1  upstream stage offers `in_data`.
- `in_ready`  out  1  buffer can accept this cycle.
- `in_data`  in  WIDTH  upstream payload.
- `out_valid`  out  1  `out_data` holds a valid entry.
- `out_ready`  in  1  downstream stage consumes this cycle.
- `out_data`  out  WIDTH  head payload.
- `count`  out  $clog2(DEPTH+1)  entries currently stored.

## Operation
- Storage: circular array of DEPTH entries, with head pointer `rd_ptr`, tail pointer `wr_ptr` and occupancy `count`.
  - Pointer width is $clog2(DEPTH), minimum 1.
  - Pointers wrap from DEPTH-1 to 0 explicitly; no reliance on power-of-two overflow.
- Push occurs when `in_valid && in_ready && !flush`.
- Pop occurs when `out_valid && out_ready && !flush`.
- `in_ready = (count != DEPTH)`.
  - Depends on state only, never on `out_ready`. This keeps the ready chain between stages combinationally cut.
  - With a full buffer, a simultaneous pop does not allow a push in the same cycle.
- Simultaneous push and pop (count not 0 and not DEPTH): `count` is unchanged and both pointers advance.
- PASS=0:
  - `out_valid = (count != 0)`.
  - `out_data` is the entry at `rd_ptr` when valid, and `'0` when not valid.
- PASS=1:
  - When `count == 0`: `out_valid = in_valid`, `out_data = in_data`, `in_ready = 1`.
  - If `out_ready` is also high in that case, the entry bypasses storage: no push, and `count` stays 0.
  - When `count != 0`: behaves exactly as PASS=0, and ordering is preserved (new input is queued behind the head).
- Flush:
  - Has the highest priority. `out_valid` is forced to 0 during the flush cycle.
  - Push and pop are suppressed in the flush cycle.
  - Next cycle: `count = 0`, `rd_ptr = wr_ptr = 0`.
  - Flush when already empty has no effect beyond pointer reset.
- Payload storage is not cleared by flush or reset; only the pointers and `count` are. `out_data` masking to `'0` hides stale contents.

## Timing
- Reset (asynchronous):
  - `count = 0`, both pointers 0.
  - Outputs during and immediately after reset: `out_valid = 0`, `out_data = '0`, `in_ready = 1`.
- Latency from push to `out_valid`:
  - PASS=0: 1 cycle.
  - PASS=1 with an empty buffer: 0 cycles (combinational).
- Throughput: one entry per cycle sustained whenever `count < DEPTH`. With DEPTH=1 and PASS=0, throughput is one entry every 2 cycles under continuous back-pressure release; this is accepted and documented.
- Reset asserted mid-operation: all entries are lost immediately. No push or pop is honoured in that cycle.
- `flush` and `reset` are both level signals. `flush` held high for N cycles keeps the buffer empty and `out_valid = 0` for N cycles.

## Structure
- Add to package `pipes`:
  - `PIPE_BUF_DEPTH_MAX = 8`.
  - A `pipe_hs_t` struct (`valid`, `ready`) for stage-to-stage handshakes.
  - The per-stage `*_data_t` structs remain the payload types.
- Payload is a flat `logic [WIDTH-1:0]`; callers cast to and from the stage struct.
- No sub-module; the storage array is inline.
- Instantiated once per stage boundary in the core top.

## Test plan
- **Fill and drain.** DEPTH=2, PASS=0. Push 0x11 then 0x22 with `out_ready=0`.
  - `count` goes to 2 and `in_ready` goes to 0.
  - A third push of 0x33 is not accepted.
  - Raising `out_ready` yields 0x11 then 0x22.
- **Wrap-around.** DEPTH=3. Stream 10 entries 0x1..0xA with `out_ready` toggling every cycle.
  - Output order is exactly 0x1..0xA with no loss or duplication.
  - `count` never exceeds 3.
- **Full with simultaneous pop.** DEPTH=2, full, `out_ready=1`, `in_valid=1`.
  - Pop of the head occurs.
  - No push that cycle (`in_ready=0`).
  - Next cycle `count=1`.
- **Fall-through.** PASS=1, empty, `in_valid=1`, `in_data=0xABCD`, `out_ready=1`.
  - `out_valid=1` and `out_data=0xABCD` in the same cycle.
  - `count` stays 0.
  - With `out_ready=0`, the entry is stored and `count=1` next cycle.
- **Flush.** DEPTH=4, 3 entries stored, `flush=1` with `in_valid=1`.
  - `out_valid=0` in the flush cycle.
  - Next cycle `count=0` and `out_data='0`.
  - The offered entry is never output.
- **Async reset.** `reset` asserted mid-cycle with 2 entries stored.
  - `out_valid` drops to 0 immediately, before the clock edge.
  - After release: `in_ready=1`, `count=0`.

Source files
------------

// File: rtl/pipe_buffer_pkg.sv
// Shared pipeline types: stage-to-stage handshake and elastic buffer limits.
package pipes;

   // Largest supported elastic buffer depth between two stages.
   localparam int PIPE_BUF_DEPTH_MAX = 8;

   // Valid/ready pair travelling between adjacent pipeline stages.
   typedef struct packed {
      logic valid;
      logic ready;
   } pipe_hs_t;

endpackage : pipes

// File: rtl/pipe_buffer.sv
// Elastic buffer between two pipeline stages: circular storage of DEPTH
// payloads with valid/ready back-pressure, synchronous flush and an optional
// zero-latency fall-through path when empty.
module pipe_buffer
   import pipes::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2,
   parameter int PASS  = 0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

   // Payload storage is deliberately never cleared; out_data masking hides
   // stale entries instead.
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;

   logic             empty;
   logic             full;
   logic             bypass_mode;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] sel_data;

   // Explicit wrap so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      logic [PTR_W-1:0] n;
      if (p == LAST_PTR) begin
         n = {PTR_W{1'b0}};
      end else begin
         n = p + PTR_W'(1);
      end
      return n;
   endfunction

   // Handshake decode: ready from state only, flush masks valid, bypass when empty in PASS mode.
   always_comb begin
      empty       = (count == {CNT_W{1'b0}});
      full        = (count == FULL_CNT);
      in_ready    = !full;
      bypass_mode = (PASS != 0) && empty;

      if (flush) begin
         out_valid = 1'b0;
      end else if (bypass_mode) begin
         out_valid = in_valid;
      end else begin
         out_valid = !empty;
      end

      if (bypass_mode) begin
         sel_data = in_data;
      end else begin
         sel_data = mem[rd_ptr];
      end

      if (out_valid) begin
         out_data = sel_data;
      end else begin
         out_data = {WIDTH{1'b0}};
      end

      // A bypassed entry goes straight through and never touches storage.
      push = in_valid && in_ready && !flush && !(bypass_mode && out_ready);
      pop  = out_valid && out_ready && !bypass_mode;
   end

   // Pointer and occupancy state; flush and reset both return to empty.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= {PTR_W{1'b0}};
         wr_ptr <= {PTR_W{1'b0}};
         count  <= {CNT_W{1'b0}};
      end else if (flush) begin
         rd_ptr <= {PTR_W{1'b0}};
         wr_ptr <= {PTR_W{1'b0}};
         count  <= {CNT_W{1'b0}};
      end else begin
         if (push) begin
            wr_ptr <= next_ptr(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Payload write at the tail on every accepted push.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_data;
      end
   end

endmodule : pipe_buffer

// File: tb/tb_pipe_buffer.sv
// Directed bench for pipe_buffer: four instances covering registered,
// odd-depth, flush and fall-through configurations.
module tb_pipe_buffer;

   logic clk = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   // A: DEPTH=2 PASS=0
   logic        a_reset, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [15:0] a_in_data, a_out_data;
   logic [1:0]  a_count;
   // B: DEPTH=3 PASS=0
   logic        b_reset, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [15:0] b_in_data, b_out_data;
   logic [1:0]  b_count;
   // C: DEPTH=4 PASS=0
   logic        c_reset, c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
   logic [15:0] c_in_data, c_out_data;
   logic [2:0]  c_count;
   // D: DEPTH=2 PASS=1
   logic        d_reset, d_flush, d_in_valid, d_in_ready, d_out_valid, d_out_ready;
   logic [15:0] d_in_data, d_out_data;
   logic [1:0]  d_count;

   pipe_buffer #(.WIDTH(16), .DEPTH(2), .PASS(0)) u_a (
      .clk(clk), .reset(a_reset), .flush(a_flush), .in_valid(a_in_valid),
      .in_ready(a_in_ready), .in_data(a_in_data), .out_valid(a_out_valid),
      .out_ready(a_out_ready), .out_data(a_out_data), .count(a_count));

   pipe_buffer #(.WIDTH(16), .DEPTH(3), .PASS(0)) u_b (
      .clk(clk), .reset(b_reset), .flush(b_flush), .in_valid(b_in_valid),
      .in_ready(b_in_ready), .in_data(b_in_data), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .out_data(b_out_data), .count(b_count));

   pipe_buffer #(.WIDTH(16), .DEPTH(4), .PASS(0)) u_c (
      .clk(clk), .reset(c_reset), .flush(c_flush), .in_valid(c_in_valid),
      .in_ready(c_in_ready), .in_data(c_in_data), .out_valid(c_out_valid),
      .out_ready(c_out_ready), .out_data(c_out_data), .count(c_count));

   pipe_buffer #(.WIDTH(16), .DEPTH(2), .PASS(1)) u_d (
      .clk(clk), .reset(d_reset), .flush(d_flush), .in_valid(d_in_valid),
      .in_ready(d_in_ready), .in_data(d_in_data), .out_valid(d_out_valid),
      .out_ready(d_out_ready), .out_data(d_out_data), .count(d_count));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int exp_out;
   int idx_in;
   int cyc;

   initial begin
      a_reset = 1'b1; a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_data = 16'h0;
      b_reset = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = 16'h0;
      c_reset = 1'b1; c_flush = 1'b0; c_in_valid = 1'b0; c_out_ready = 1'b0; c_in_data = 16'h0;
      d_reset = 1'b1; d_flush = 1'b0; d_in_valid = 1'b0; d_out_ready = 1'b0; d_in_data = 16'h0;
      tick();
      tick();
      // Reset state
      chk("rst_out_valid", 32'(a_out_valid), 32'd0);
      chk("rst_out_data",  32'(a_out_data),  32'd0);
      chk("rst_in_ready",  32'(a_in_ready),  32'd1);
      chk("rst_count",     32'(a_count),     32'd0);
      a_reset = 1'b0; b_reset = 1'b0; c_reset = 1'b0; d_reset = 1'b0;
      tick();

      // Fill and drain (A)
      a_in_valid = 1'b1; a_in_data = 16'h0011;
      tick();
      chk("fill1_count", 32'(a_count), 32'd1);
      chk("fill1_valid", 32'(a_out_valid), 32'd1);
      chk("fill1_data",  32'(a_out_data), 32'h11);
      a_in_data = 16'h0022;
      tick();
      chk("fill2_count", 32'(a_count), 32'd2);
      chk("fill2_ready", 32'(a_in_ready), 32'd0);
      a_in_data = 16'h0033;
      tick();
      chk("fill3_count", 32'(a_count), 32'd2);
      chk("fill3_head",  32'(a_out_data), 32'h11);
      // Full with simultaneous pop: head pops, no push
      a_out_ready = 1'b1;
      #1;
      chk("fullpop_ready", 32'(a_in_ready), 32'd0);
      chk("fullpop_valid", 32'(a_out_valid), 32'd1);
      tick();
      chk("fullpop_count", 32'(a_count), 32'd1);
      chk("drain_data2",   32'(a_out_data), 32'h22);
      a_in_valid = 1'b0;
      tick();
      chk("drain_count", 32'(a_count), 32'd0);
      chk("drain_valid", 32'(a_out_valid), 32'd0);
      chk("drain_mask",  32'(a_out_data), 32'd0);
      a_out_ready = 1'b0;

      // Wrap-around (B): 0x1..0xA with out_ready toggling
      exp_out = 1;
      idx_in = 0;
      cyc = 0;
      while (exp_out <= 10 && cyc < 80) begin
         b_in_valid = (idx_in < 10);
         b_in_data = 16'(idx_in + 1);
         b_out_ready = cyc[0];
         #1;
         chk("wrap_count_le3", 32'(b_count <= 2'd3 && b_count != 2'd0 || b_count == 2'd0), 32'd1);
         if (b_out_valid && b_out_ready) begin
            chk("wrap_order", 32'(b_out_data), 32'(exp_out));
            exp_out++;
         end
         if (b_in_valid && b_in_ready) begin
            idx_in++;
         end
         tick();
         cyc++;
      end
      b_in_valid = 1'b0;
      b_out_ready = 1'b0;
      chk("wrap_all_out", 32'(exp_out), 32'd11);
      tick();
      chk("wrap_empty", 32'(b_count), 32'd0);

      // Flush (C): 3 stored, flush with an offered entry
      c_in_valid = 1'b1;
      c_in_data = 16'h00A1;
      tick();
      c_in_data = 16'h00A2;
      tick();
      c_in_data = 16'h00A3;
      tick();
      chk("flush_pre_count", 32'(c_count), 32'd3);
      c_flush = 1'b1; c_in_data = 16'h00EE; c_out_ready = 1'b1;
      #1;
      chk("flush_out_valid", 32'(c_out_valid), 32'd0);
      tick();
      c_flush = 1'b0; c_in_valid = 1'b0;
      #1;
      chk("flush_count", 32'(c_count), 32'd0);
      chk("flush_data",  32'(c_out_data), 32'd0);
      chk("flush_valid", 32'(c_out_valid), 32'd0);
      tick();
      chk("flush_no_ghost", 32'(c_out_valid), 32'd0);
      c_out_ready = 1'b0; c_in_valid = 1'b1; c_in_data = 16'h005A;
      tick();
      c_in_valid = 1'b0;
      chk("flush_ptr_reset", 32'(c_out_data), 32'h5A);
      chk("flush_repush_count", 32'(c_count), 32'd1);

      // Fall-through (D)
      d_in_valid = 1'b1; d_in_data = 16'hABCD; d_out_ready = 1'b1;
      #1;
      chk("ft_valid", 32'(d_out_valid), 32'd1);
      chk("ft_data",  32'(d_out_data), 32'hABCD);
      tick();
      chk("ft_count_bypass", 32'(d_count), 32'd0);
      d_out_ready = 1'b0;
      #1;
      chk("ft_valid_held", 32'(d_out_valid), 32'd1);
      tick();
      d_in_valid = 1'b0;
      #1;
      chk("ft_stored_count", 32'(d_count), 32'd1);
      chk("ft_stored_data",  32'(d_out_data), 32'hABCD);
      d_in_valid = 1'b1; d_in_data = 16'h5678; d_out_ready = 1'b1;
      #1;
      chk("ft_order_head", 32'(d_out_data), 32'hABCD);
      tick();
      d_in_valid = 1'b0;
      #1;
      chk("ft_pushpop_count", 32'(d_count), 32'd1);
      chk("ft_order_next", 32'(d_out_data), 32'h5678);
      tick();
      chk("ft_drained", 32'(d_count), 32'd0);

      // Async reset mid-cycle with 2 entries stored (A)
      a_in_valid = 1'b1; a_in_data = 16'h0044;
      tick();
      a_in_data = 16'h0055;
      tick();
      a_in_valid = 1'b0;
      chk("ar_pre_count", 32'(a_count), 32'd2);
      #2;
      a_reset = 1'b1;
      #1;
      chk("ar_valid_drop", 32'(a_out_valid), 32'd0);
      chk("ar_count_drop", 32'(a_count), 32'd0);
      #1;
      a_reset = 1'b0;
      #1;
      chk("ar_in_ready", 32'(a_in_ready), 32'd1);
      chk("ar_count", 32'(a_count), 32'd0);
      tick();
      chk("ar_stays_empty", 32'(a_out_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_pipe_buffer
